ram_sync_clr: RTL

Parametrised single-port synchronous RAM with chip-select and write/read control, registered read data with a valid strobe, and a hardware clear engine that sweeps every location to a fixed value after reset or on request. It is the next-generation data memory for the lab datapath: configurable width and depth, a defined power-up content, and an optional extra output pipeline stage for timing closure.

---
 rtl/ram_sync_clr.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with registered read data, valid strobe and a clear sweep engine.
// Define RAM_OUTREG_EN to add a second output register (read latency 2 instead of 1).
module ram_sync_clr #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              w_r,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic                acc_ok;
  logic                rd_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  // A clear request in READY takes priority over any access in the same cycle.
  always_comb begin
    in_range  = ({1'b0, address} < DEPTH_LIMIT);
    acc_ok    = (state_q == READY) && !clr && cs;
    rd_en     = acc_ok && !w_r;
    mem_we    = (state_q == CLEAR) || (acc_ok && w_r && in_range);
    mem_waddr = (state_q == CLEAR) ? ptr_q : address;
    mem_wdata = (state_q == CLEAR) ? CLEAR_VAL : data;
  end

  assign busy = (state_q == CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_PTR) state_q <= READY;
        end
        READY: begin
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the clear sweep gives it defined content instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= in_range ? mem[address] : '0;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;

  // The second stage always advances, so a read already in stage one finishes across a clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_q <= rd_data_q;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`else
  assign out       = rd_data_q;
  assign out_valid = rd_valid_q;
`endif

endmodule
